// File: rtl/joy_serial_scanner.sv
// Serial joystick scanner for a 74HC165-style chain, with per-bit debounce.
// Optional debounce counters are built when JOY_SCANNER_DEBOUNCE_EN is defined.
module joy_serial_scanner #(
  parameter int unsigned NJOY           = 2,
  parameter int unsigned JBITS          = 6,
  parameter int unsigned CLKDIV         = 14,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sr_data,
  output logic                    sr_load_n,
  output logic                    sr_clk,
  output logic [NJOY*JBITS-1:0]   joy_n,
  output logic                    scan_done
);

  localparam int unsigned N    = NJOY * JBITS;
  localparam int unsigned DIVW = $clog2(CLKDIV);
  localparam int unsigned BITW = $clog2(N);

  if (NJOY < 1 || NJOY > 4 || (JBITS != 6 && JBITS != 8) || CLKDIV < 2 ||
      DEBOUNCE_SCANS < 1) begin : g_param_check
    $error("joy_serial_scanner: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_LOW, S_HIGH, S_UPDATE
  } state_t;

  state_t          state, state_next;
  logic [DIVW-1:0] div;
  logic [BITW-1:0] idx, idx_next;
  logic [N-1:0]    raw;
  logic            tick;
  logic            capture;
  logic            load_n_next;
  logic            clk_next;

  assign tick = (div == DIVW'(CLKDIV - 1));

  // Free-running tick divider
  always_ff @(posedge sysclk) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + DIVW'(1);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      sr_load_n <= 1'b1;
      sr_clk    <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      sr_load_n <= load_n_next;
      sr_clk    <= clk_next;
      scan_done <= (state == S_UPDATE);
    end
  end

  // UPDATE is a single cycle so UPDATE plus IDLE together take one tick period
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      S_IDLE:   if (tick && enable) state_next = S_LOAD;
      S_LOAD:   if (tick) state_next = S_SETTLE;
      S_SETTLE: if (tick) begin
        state_next = S_LOW;
        idx_next   = '0;
      end
      S_LOW:    if (tick) begin
        capture    = 1'b1;
        state_next = (idx == BITW'(N - 1)) ? S_UPDATE : S_HIGH;
      end
      S_HIGH:   if (tick) begin
        state_next = S_LOW;
        idx_next   = idx + BITW'(1);
      end
      S_UPDATE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    load_n_next = (state_next != S_LOAD);
    clk_next    = (state_next == S_HIGH);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n)       raw      <= '1;
    else if (capture) raw[idx] <= sr_data;
  end

`ifdef JOY_SCANNER_DEBOUNCE_EN
  localparam int unsigned CNTW = $clog2(DEBOUNCE_SCANS) + 1;

  logic [CNTW-1:0] cnt [N];

  // A bit flips only after DEBOUNCE_SCANS consecutive disagreeing scans
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      joy_n <= '1;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (state == S_UPDATE) begin
      for (int i = 0; i < N; i++) begin
        if (raw[i] == joy_n[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNTW'(DEBOUNCE_SCANS - 1)) begin
          joy_n[i] <= raw[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNTW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge sysclk) begin
    if (!rst_n)                 joy_n <= '1;
    else if (state == S_UPDATE) joy_n <= raw;
  end
`endif

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Scoreboard bench for joy_serial_scanner: chain model feeds patterns, a
// history-based reference predicts joy_n, a negedge monitor checks timing.
module tb_joy_serial_scanner;

  localparam int unsigned NJOY   = 2;
  localparam int unsigned JBITS  = 6;
  localparam int unsigned CLKDIV = 4;
  localparam int unsigned DSCANS = 3;
  localparam int unsigned N      = NJOY * JBITS;
  localparam int unsigned PERIOD = (2 * N + 2) * CLKDIV;
`ifdef JOY_SCANNER_DEBOUNCE_EN
  localparam int unsigned DS_EFF = DSCANS;
`else
  localparam int unsigned DS_EFF = 1;
`endif

  logic         sysclk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         enable = 1'b0;
  logic         sr_data;
  logic         sr_load_n;
  logic         sr_clk;
  logic [N-1:0] joy_n;
  logic         scan_done;

  int checks = 0;
  int errors = 0;

  joy_serial_scanner #(
    .NJOY(NJOY), .JBITS(JBITS), .CLKDIV(CLKDIV), .DEBOUNCE_SCANS(DSCANS)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .sr_data(sr_data),
    .sr_load_n(sr_load_n), .sr_clk(sr_clk), .joy_n(joy_n), .scan_done(scan_done)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Chain model and reference
  logic [N-1:0] shreg   = '1;
  logic [N-1:0] cur_pat = '1;
  logic [N-1:0] acc     = '1;
  logic [N-1:0] pat_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] exp_q[$];
  logic         c_load_prev = 1'b1;
  logic         c_clk_prev  = 1'b0;

  assign sr_data = shreg[0];

  // A bit changes once the last DS_EFF scans all disagree with its accepted value
  task automatic model_scan(input logic [N-1:0] pat);
    logic all_diff;
    hist.push_back(pat);
    if (hist.size() > int'(DS_EFF)) void'(hist.pop_front());
    if (hist.size() == int'(DS_EFF)) begin
      for (int b = 0; b < int'(N); b++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][b] == acc[b]) all_diff = 1'b0;
        if (all_diff) acc[b] = ~acc[b];
      end
    end
    exp_q.push_back(acc);
  endtask

  always @(posedge sysclk) begin
    if (!rst_n) begin
      shreg <= '1;
      acc = '1;
      hist.delete();
      exp_q.delete();
      c_load_prev = 1'b1;
      c_clk_prev  = 1'b0;
    end else begin
      if (sr_load_n === 1'b0) begin
        if (c_load_prev === 1'b1) begin
          if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
          model_scan(cur_pat);
        end
        shreg <= cur_pat;
      end else if (sr_clk === 1'b1 && c_clk_prev === 1'b0) begin
        shreg <= {1'b1, shreg[N-1:1]};
      end
      c_load_prev = sr_load_n;
      c_clk_prev  = sr_clk;
    end
  end

  // Monitor
  int   edges = 0, load_len = 0, since = 0, done_count = 0;
  int   total_loads = 0, total_rises = 0, rst_rises = 0;
  logic gap = 1'b1;
  logic m_load_prev = 1'b1;
  logic m_clk_prev  = 1'b0;

  always @(negedge sysclk) begin
    if (!rst_n) begin
      if (sr_clk === 1'b1 && m_clk_prev === 1'b0) rst_rises++;
      gap = 1'b1; edges = 0; load_len = 0; since = 0;
    end else begin
      since++;
      if (!enable) gap = 1'b1;
      if (sr_load_n === 1'b0) begin
        if (m_load_prev === 1'b1) total_loads++;
        load_len++;
        edges = 0;
      end else if (m_load_prev === 1'b0) begin
        check("load_low_cycles", load_len, CLKDIV);
        load_len = 0;
      end
      if (sr_clk === 1'b1 && m_clk_prev === 1'b0) begin
        edges++;
        total_rises++;
      end
      if (scan_done === 1'b1) begin
        done_count++;
        check("sr_clk_rises_per_scan", edges, N - 1);
        if (!gap) check("scan_done_period", since, PERIOD);
        gap = 1'b0;
        since = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: scan_done with no expected entry, joy_n=%h", joy_n);
        end else begin
          check("joy_n_scoreboard", 32'(joy_n), 32'(exp_q.pop_front()));
        end
      end
    end
    m_load_prev = sr_load_n;
    m_clk_prev  = sr_clk;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wait_scans(input int n, input string name);
    int target;
    int budget;
    target = done_count + n;
    budget = (n + 4) * int'(PERIOD);
    while (done_count < target && budget > 0) begin
      @(posedge sysclk); #1;
      budget--;
    end
    if (done_count < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got %0d scan_done required %0d", name, done_count, target);
    end
  endtask

  task automatic wait_edges(input int k, input string name);
    int budget;
    budget = 4 * int'(PERIOD);
    while (edges != k && budget > 0) begin
      @(posedge sysclk); #1;
      budget--;
    end
    if (edges != k) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, edges %0d required %0d", name, edges, k);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_joy_n"},     32'(joy_n),     32'(12'hFFF));
    check({tag, "_sr_load_n"}, 32'(sr_load_n), 32'(1'b1));
    check({tag, "_sr_clk"},    32'(sr_clk),    32'(1'b0));
    check({tag, "_scan_done"}, 32'(scan_done), 32'(1'b0));
  endtask

  logic [N-1:0] stim_pat;
  logic [2:0]   gexp;
  logic [N-1:0] joy_snap;
  int           loads_snap, rises_snap, done_snap, nscans, rep, budget;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    wait_cycles(5);
    check_reset_values("reset");
    check("reset_sr_clk_edges", rst_rises, 0);
    rst_n = 1'b1;

    // Bit mapping: only joystick 1 fire1 (index 10) pressed
    stim_pat = '1;
    stim_pat[10] = 1'b0;
    pat_q.push_back(stim_pat);
    enable = 1'b1;
`ifdef JOY_SCANNER_DEBOUNCE_EN
    wait_scans(2, "map_pre");
    check("map_before_accept", 32'(joy_n), 32'(12'hFFF));
    wait_scans(1, "map_accept");
`else
    wait_scans(1, "map_accept");
`endif
    check("map_accept", 32'(joy_n), 32'(12'hBFF));

    // Two-scan glitch on joystick 0 up
`ifdef JOY_SCANNER_DEBOUNCE_EN
    gexp = 3'b111;
`else
    gexp = 3'b100;
`endif
    stim_pat[0] = 1'b0;
    pat_q.push_back(stim_pat);
    pat_q.push_back(stim_pat);
    stim_pat[0] = 1'b1;
    pat_q.push_back(stim_pat);
    for (int k = 0; k < 3; k++) begin
      wait_scans(1, "glitch");
      check("glitch_joy0", 32'(joy_n[0]), 32'(gexp[k]));
    end

    // Random patterns, some held long enough to pass debounce
    nscans = 0;
    for (int s = 0; s < 14; s++) begin
      for (int b = 0; b < int'(N); b++)
        if ($urandom_range(3) == 0) stim_pat[b] = ~stim_pat[b];
      rep = int'($urandom_range(1, 4));
      for (int r = 0; r < rep; r++) pat_q.push_back(stim_pat);
      nscans += rep;
    end
    wait_scans(nscans, "random");

    // Enable drop during HIGH_3
    wait_edges(4, "enable_drop_sync");
    enable = 1'b0;
    wait_scans(1, "enable_drop_finish");
    loads_snap = total_loads;
    rises_snap = total_rises;
    done_snap  = done_count;
    joy_snap   = joy_n;
    wait_cycles(3 * int'(PERIOD));
    check("disabled_no_load",      total_loads, loads_snap);
    check("disabled_no_sr_clk",    total_rises, rises_snap);
    check("disabled_no_scan_done", done_count,  done_snap);
    check("disabled_joy_hold",     32'(joy_n),  32'(joy_snap));

    // Reset for one cycle during HIGH_5
    for (int b = 0; b < int'(N); b++) stim_pat[b] = 1'($urandom_range(1));
    stim_pat[3] = 1'b0;
    pat_q.push_back(stim_pat);
    enable = 1'b1;
    wait_edges(6, "reset_mid_sync");
    rst_n = 1'b0;
    wait_cycles(1);
    check_reset_values("midreset");
    rst_n = 1'b1;
    rises_snap = total_rises;
    loads_snap = total_loads;
    budget = 4 * int'(CLKDIV);
    while (total_loads == loads_snap && budget > 0) begin
      wait_cycles(1);
      budget--;
    end
    check("post_reset_load_seen", total_loads, loads_snap + 1);
    check("post_reset_no_sr_clk_before_load", total_rises, rises_snap);
    wait_scans(DS_EFF + 1, "post_reset_scans");

    wait_cycles(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
